// File: rtl/warp_kernel_fetch_if.sv
// Kernel-fetch port bundle: launch/status, memory read request/response, instruction stream.
// Latency: none, wires only.
// Backpressure: mem_req and instr use valid/ready; mem_resp is always accepted by the fetch unit.
interface warp_kernel_fetch_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  kernel_start;
    logic [31:0]           kernel_addr;
    logic [15:0]           kernel_length;
    logic                  kernel_done;
    logic                  kernel_error;
    logic                  busy;

    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic                  mem_req_write;
    logic                  mem_resp_valid;
    logic                  mem_resp_ready;
    logic [31:0]           mem_resp_data;

    logic                  instr_valid;
    logic                  instr_ready;
    logic [31:0]           instr_data;
    logic [ADDR_WIDTH-1:0] instr_pc;
    logic                  instr_last;

    // Fetch unit side
    modport master (
        input  kernel_start, kernel_addr, kernel_length,
        output kernel_done, kernel_error, busy,
        output mem_req_valid, mem_req_addr, mem_req_write,
        input  mem_req_ready,
        input  mem_resp_valid, mem_resp_data,
        output mem_resp_ready,
        output instr_valid, instr_data, instr_pc, instr_last,
        input  instr_ready
    );

    // Decoder / memory / front-end side
    modport slave (
        output kernel_start, kernel_addr, kernel_length,
        input  kernel_done, kernel_error, busy,
        input  mem_req_valid, mem_req_addr, mem_req_write,
        output mem_req_ready,
        output mem_resp_valid, mem_resp_data,
        input  mem_resp_ready,
        input  instr_valid, instr_data, instr_pc, instr_last,
        output instr_ready
    );
endinterface

// File: rtl/warp_kernel_fetch.sv
// Kernel fetch: streams kernel_length words from kernel_addr into a FWFT buffer for the warp front-end.
// Latency: first read request 1 cycle after start; done pulse 1 cycle after the last instruction pop.
// Backpressure: requests are credit-limited by outstanding reads plus buffer occupancy; responses never drop.
package warp_pkg;
    localparam int ADDR_WIDTH = 16;
endpackage

module warp_kernel_fetch #(
    parameter int ADDR_WIDTH      = warp_pkg::ADDR_WIDTH,
    parameter int FIFO_DEPTH      = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    warp_kernel_fetch_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FINISH} state_t;

    typedef struct packed {
        logic [31:0]           data;
        logic [ADDR_WIDTH-1:0] pc;
        logic                  last;
    } entry_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] base;
    logic [15:0]           length;
    logic [16:0]           issue_cnt;
    logic [16:0]           ret_cnt;
    logic [OW-1:0]         outstanding;
    logic                  err_flag;

    entry_t                fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_empty;

    logic [32:0]           addr_end;
    logic [32:0]           addr_lim;
    logic                  launch_err;
    logic                  start_acc;
    logic                  req_valid;
    logic                  req_hs;
    logic                  push;
    logic                  pop;
    entry_t                push_entry;
    entry_t                head;
    logic                  busy_o, done_o, error_o;

    // Launch checks: alignment, address range, and end of kernel within the address space (33-bit sum)
    assign addr_end   = {1'b0, bus.kernel_addr} + {15'b0, bus.kernel_length, 2'b00};
    assign addr_lim   = 33'd1 << ADDR_WIDTH;
    assign launch_err = (bus.kernel_addr[1:0] != 2'b00)
                     || ((bus.kernel_addr >> ADDR_WIDTH) != 32'd0)
                     || (addr_end > addr_lim);
    assign start_acc  = (state == IDLE) && bus.kernel_start;

    assign req_hs     = req_valid && bus.mem_req_ready;
    // Responses are only meaningful while fetching; anything else is stray and discarded
    assign push       = bus.mem_resp_valid && (state == FETCH);
    assign fifo_empty = (fifo_count == '0);
    assign pop        = !fifo_empty && bus.instr_ready;
    assign head       = fifo_empty ? '0 : fifo_mem[rd_ptr];

    assign push_entry.data = bus.mem_resp_data;
    assign push_entry.pc   = base + ADDR_WIDTH'({ret_cnt, 2'b00});
    assign push_entry.last = (ret_cnt == ({1'b0, length} - 17'd1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; the last entry may be popped while still in FETCH, so both states watch for it
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.kernel_start) begin
                    if (launch_err || (bus.kernel_length == 16'd0)) state_nxt = FINISH;
                    else                                            state_nxt = FETCH;
                end
            end
            FETCH: begin
                if (pop && head.last)                  state_nxt = FINISH;
                else if (ret_cnt == {1'b0, length})    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (pop && head.last) state_nxt = FINISH;
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state: status pulses and credit-gated request valid
    always_comb begin
        busy_o    = 1'b0;
        done_o    = 1'b0;
        error_o   = 1'b0;
        req_valid = 1'b0;
        case (state)
            FETCH: begin
                busy_o    = 1'b1;
                req_valid = (issue_cnt < {1'b0, length})
                         && (outstanding < OW'(MAX_OUTSTANDING))
                         && ((32'(outstanding) + 32'(fifo_count)) < 32'(FIFO_DEPTH));
            end
            DRAIN:  busy_o = 1'b1;
            FINISH: begin
                busy_o  = 1'b1;
                done_o  = !err_flag;
                error_o = err_flag;
            end
            default: ;
        endcase
    end

    // Kernel context and request/response bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base        <= '0;
            length      <= '0;
            issue_cnt   <= '0;
            ret_cnt     <= '0;
            outstanding <= '0;
            err_flag    <= 1'b0;
        end else if (start_acc) begin
            base        <= bus.kernel_addr[ADDR_WIDTH-1:0];
            length      <= bus.kernel_length;
            issue_cnt   <= '0;
            ret_cnt     <= '0;
            outstanding <= '0;
            err_flag    <= launch_err;
        end else begin
            if (req_hs) issue_cnt <= issue_cnt + 17'd1;
            if (push)   ret_cnt   <= ret_cnt + 17'd1;
            case ({req_hs, push})
                2'b10:   outstanding <= outstanding + OW'(1);
                2'b01:   outstanding <= outstanding - OW'(1);
                default: ;
            endcase
        end
    end

    // Buffer pointers and occupancy; simultaneous push and pop leave the count unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: ;
            endcase
        end
    end

    // Buffer storage; contents are qualified by the occupancy count so no reset is needed
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= push_entry;
    end

    assign bus.busy           = busy_o;
    assign bus.kernel_done    = done_o;
    assign bus.kernel_error   = error_o;
    assign bus.mem_req_valid  = req_valid;
    assign bus.mem_req_addr   = base + ADDR_WIDTH'({issue_cnt, 2'b00});
    assign bus.mem_req_write  = 1'b0;
    assign bus.mem_resp_ready = 1'b1;
    assign bus.instr_valid    = !fifo_empty;
    assign bus.instr_data     = head.data;
    assign bus.instr_pc       = head.pc;
    assign bus.instr_last     = head.last;
endmodule

// File: tb/tb_warp_kernel_fetch.sv
// Self-checking bench for warp_kernel_fetch: random and directed kernels against a queue-based model.
// Latency: checks request timing, done/error pulse timing and busy fall.
// Backpressure: random ready on memory requests and instruction consumer, configurable memory latency.
module tb_warp_kernel_fetch;
    localparam int AW    = 16;
    localparam int DEPTH = 8;
    localparam int MAXO  = 4;

    typedef struct { logic [31:0] data; logic [31:0] pc; bit last; } instr_t;
    typedef struct { bit is_err; int due; } end_t;
    typedef struct { logic [31:0] addr; int due; } pend_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    warp_kernel_fetch_if #(.ADDR_WIDTH(AW)) bus();

    warp_kernel_fetch #(
        .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    instr_t      exp_instr[$];
    logic [31:0] exp_req[$];
    end_t        exp_end[$];
    pend_t       pending[$];
    int          req_cyc[$];
    int          resp_cyc[$];

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int model_out = 0;
    int model_fifo = 0;
    int last_pop_cyc = 0;
    int instr_pct = 100;
    int mem_pct = 100;
    int lat = 1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input bit ok, input longint act, input longint req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        logic [2*32+2*AW+6:0] all;
        all = {bus.kernel_done, bus.kernel_error, bus.busy, bus.mem_req_valid, bus.mem_req_write,
               bus.instr_valid, bus.instr_last, bus.instr_data, bus.instr_pc, bus.mem_req_addr, 32'd0};
        checks++;
        if (all !== '0 || bus.mem_resp_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s: outputs=%h resp_ready=%b, expected all zero and resp_ready=1",
                     name, all, bus.mem_resp_ready);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_instr.delete();
        exp_req.delete();
        exp_end.delete();
        pending.delete();
        req_cyc.delete();
        resp_cyc.delete();
        model_out  = 0;
        model_fifo = 0;
        #1;
        check_reset_outputs("reset_mid");
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Reference model: expected requests, instruction stream and ending pulse from the launch rules
    task automatic launch(input logic [31:0] a, input int len, output int s);
        longint lim;
        longint endb;
        bit     err;
        lim  = longint'(1) << AW;
        endb = longint'(a) + 4 * longint'(len);
        err  = (a % 4 != 0) || (longint'(a) >= lim) || (endb > lim);
        s = cyc;
        bus.kernel_start  = 1'b1;
        bus.kernel_addr   = a;
        bus.kernel_length = 16'(len);
        if (err) begin
            exp_end.push_back('{is_err: 1'b1, due: s + 1});
        end else if (len == 0) begin
            exp_end.push_back('{is_err: 1'b0, due: s + 1});
        end else begin
            for (int i = 0; i < len; i++) begin
                logic [31:0] pc;
                pc = a + 32'(4 * i);
                exp_req.push_back(pc);
                exp_instr.push_back('{data: mem_word(pc), pc: pc, last: (i == len - 1)});
            end
            exp_end.push_back('{is_err: 1'b0, due: -1});
        end
        tick();
        bus.kernel_start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_end.size() != 0 || bus.busy) && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: kernel still busy after %0d cycles, expected completion", name, n);
            do_reset();
        end else begin
            check({name, "_leftover"}, exp_instr.size() == 0 && exp_req.size() == 0,
                  exp_instr.size() + exp_req.size(), 0);
        end
    endtask

    // Memory and consumer driver: random readies, in-order responses released when due
    initial begin
        pend_t p;
        bus.instr_ready    = 1'b0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.instr_ready    = (int'($urandom_range(99)) < instr_pct);
            bus.mem_req_ready  = (int'($urandom_range(99)) < mem_pct);
            bus.mem_resp_valid = 1'b0;
            bus.mem_resp_data  = '0;
            if (rst_n && pending.size() > 0 && cyc >= pending[0].due) begin
                p = pending.pop_front();
                bus.mem_resp_valid = 1'b1;
                bus.mem_resp_data  = mem_word(p.addr);
            end
        end
    end

    // Monitor: compares every handshake and pulse against the scoreboard queues
    initial begin
        instr_t      e;
        end_t        en;
        logic [31:0] ea;
        bit          req_hs, resp_hs, pop, busy_chk;
        int          exp_due;
        busy_chk = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_chk = 1'b0;
                continue;
            end
            req_hs  = bus.mem_req_valid && bus.mem_req_ready;
            resp_hs = bus.mem_resp_valid;
            pop     = bus.instr_valid && bus.instr_ready;

            if (req_hs) begin
                checks++;
                if (exp_req.size() == 0) begin
                    failures++;
                    $display("FAIL req_extra: addr=%h issued, expected no further request", bus.mem_req_addr);
                end else begin
                    ea = exp_req.pop_front();
                    if (32'(bus.mem_req_addr) !== ea) begin
                        failures++;
                        $display("FAIL req_addr: got %h, expected %h", bus.mem_req_addr, ea);
                    end
                end
                checks++;
                if (model_out >= MAXO || model_out + model_fifo >= DEPTH) begin
                    failures++;
                    $display("FAIL req_credit: issued with outstanding=%0d buffered=%0d, limits %0d/%0d",
                             model_out, model_fifo, MAXO, DEPTH);
                end
                pending.push_back('{addr: 32'(bus.mem_req_addr), due: cyc + lat});
                req_cyc.push_back(cyc);
            end

            if (resp_hs) resp_cyc.push_back(cyc);

            if (pop) begin
                checks++;
                if (exp_instr.size() == 0) begin
                    failures++;
                    $display("FAIL instr_extra: pc=%h delivered, expected none", bus.instr_pc);
                end else begin
                    e = exp_instr.pop_front();
                    if (bus.instr_data !== e.data || 32'(bus.instr_pc) !== e.pc || bus.instr_last !== e.last) begin
                        failures++;
                        $display("FAIL instr: got data=%h pc=%h last=%b, expected data=%h pc=%h last=%b",
                                 bus.instr_data, bus.instr_pc, bus.instr_last, e.data, e.pc, e.last);
                    end
                    if (e.last) last_pop_cyc = cyc;
                end
            end

            model_out  = model_out + int'(req_hs) - int'(resp_hs);
            model_fifo = model_fifo + int'(resp_hs) - int'(pop);
            checks++;
            if (model_out > MAXO || model_out < 0 || model_fifo < 0 || model_fifo + model_out > DEPTH) begin
                failures++;
                $display("FAIL invariant: outstanding=%0d buffered=%0d, limits %0d/%0d",
                         model_out, model_fifo, MAXO, DEPTH);
            end

            if (bus.kernel_done || bus.kernel_error) begin
                checks++;
                if (exp_end.size() == 0) begin
                    failures++;
                    $display("FAIL pulse_extra: done=%b error=%b, expected no pulse", bus.kernel_done, bus.kernel_error);
                end else begin
                    en = exp_end.pop_front();
                    exp_due = (en.due < 0) ? last_pop_cyc + 1 : en.due;
                    if (bus.kernel_error !== en.is_err || bus.kernel_done !== !en.is_err ||
                        cyc != exp_due || bus.busy !== 1'b1) begin
                        failures++;
                        $display("FAIL pulse: got done=%b error=%b busy=%b cycle=%0d, expected done=%b error=%b busy=1 cycle=%0d",
                                 bus.kernel_done, bus.kernel_error, bus.busy, cyc, !en.is_err, en.is_err, exp_due);
                    end
                end
                busy_chk = 1'b1;
            end else if (busy_chk) begin
                busy_chk = 1'b0;
                checks++;
                if (bus.busy !== 1'b0) begin
                    failures++;
                    $display("FAIL busy_fall: busy=%b after pulse, expected 0", bus.busy);
                end
            end
        end
    end

    initial begin
        int s, b, rb, n, len;
        logic [31:0] a;
        bus.kernel_start  = 1'b0;
        bus.kernel_addr   = '0;
        bus.kernel_length = '0;

        repeat (3) tick();
        check_reset_outputs("reset_init");
        rst_n = 1'b1;
        tick();

        // Basic three-word kernel, back-to-back requests from the cycle after start
        instr_pct = 100; mem_pct = 100; lat = 1;
        tick();
        b = req_cyc.size();
        launch(32'h100, 3, s);
        wait_idle("basic");
        check("basic_req_count", req_cyc.size() - b == 3, req_cyc.size() - b, 3);
        if (req_cyc.size() - b >= 3)
            check("basic_req_timing", req_cyc[b] == s + 1 && req_cyc[b+1] == s + 2 && req_cyc[b+2] == s + 3,
                  req_cyc[b], s + 1);

        // Second start while busy is ignored
        instr_pct = 50;
        tick();
        launch(32'h300, 6, s);
        tick();
        bus.kernel_start  = 1'b1;
        bus.kernel_addr   = 32'h800;
        bus.kernel_length = 16'd2;
        tick();
        bus.kernel_start  = 1'b0;
        wait_idle("ignored_start");

        // Zero length, launch errors, and an exactly-fitting kernel at the top of memory
        instr_pct = 100;
        launch(32'h40, 0, s);                      wait_idle("zero_len");
        launch(32'h102, 4, s);                     wait_idle("err_align");
        launch(32'h0001_0000 - 32'd8, 3, s);       wait_idle("err_overrun");
        launch(32'h0001_0000, 1, s);               wait_idle("err_upper");
        launch(32'h0001_0000 - 32'd12, 3, s);      wait_idle("top_fit");

        // Backpressure: consumer stalled, buffer credits cap the requests
        instr_pct = 0; mem_pct = 100; lat = 1;
        tick();
        b = req_cyc.size();
        launch(32'h200, 20, s);
        repeat (30) tick();
        check("bp_req_count", req_cyc.size() - b == DEPTH, req_cyc.size() - b, DEPTH);
        check("bp_req_valid_low", bus.mem_req_valid == 1'b0, bus.mem_req_valid, 0);
        instr_pct = 100;
        wait_idle("backpressure");

        // Outstanding cap with slow memory
        instr_pct = 100; mem_pct = 100; lat = 10;
        tick();
        b  = req_cyc.size();
        rb = resp_cyc.size();
        launch(32'h400, 12, s);
        wait_idle("cap");
        if (req_cyc.size() - b >= 5 && resp_cyc.size() - rb >= 1) begin
            check("cap_four_inflight", req_cyc[b+3] < resp_cyc[rb], req_cyc[b+3], resp_cyc[rb]);
            check("cap_fifth_req", req_cyc[b+4] == resp_cyc[rb] + 1, req_cyc[b+4], resp_cyc[rb] + 1);
        end else begin
            check("cap_counts", 1'b0, req_cyc.size() - b, 12);
        end

        // Reset in the middle of a kernel with three words buffered
        instr_pct = 0; mem_pct = 100; lat = 1;
        tick();
        rb = resp_cyc.size();
        launch(32'h500, 10, s);
        n = 0;
        while (resp_cyc.size() - rb < 3 && n < 100) begin
            tick();
            n++;
        end
        check("rst_buffered", resp_cyc.size() - rb >= 3, resp_cyc.size() - rb, 3);
        do_reset();
        instr_pct = 100;
        launch(32'h600, 4, s);
        wait_idle("after_reset");

        // Randomized kernels
        for (int k = 0; k < 25; k++) begin
            len = $urandom_range(24);
            a   = 32'($urandom_range(16'hFF00)) & ~32'd3;
            if (k % 7 == 3) a = a | 32'd1;
            if (k % 5 == 4) a = 32'h0001_0000 - 32'(4 * $urandom_range(len + 2));
            case ($urandom_range(2))
                0:       instr_pct = 100;
                1:       instr_pct = 70;
                default: instr_pct = 30;
            endcase
            mem_pct = ($urandom_range(1) == 0) ? 100 : 60;
            lat     = $urandom_range(1, 6);
            tick();
            launch(a, len, s);
            wait_idle("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
